// File: rtl/mine_placer_if.sv
`default_nettype none
// ============================================================================
// Module      : mine_placer_if
// Description : Level-strobe, status and cell read-port bundle for mine_placer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mine_placer_if;
    logic       level_enable;
    logic [4:0] button_num;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic       busy;
    logic       done;
    logic [5:0] mine_cnt;
    logic [4:0] board_dim;
    logic       rd_mine;
    logic [3:0] rd_adj;

    modport master (
        output level_enable, button_num, rd_x, rd_y,
        input  busy, done, mine_cnt, board_dim, rd_mine, rd_adj
    );

    modport slave (
        input  level_enable, button_num, rd_x, rd_y,
        output busy, done, mine_cnt, board_dim, rd_mine, rd_adj
    );
endinterface
`default_nettype wire

// File: rtl/mine_placer.sv
`default_nettype none
// ============================================================================
// Module      : mine_placer
// Description : LFSR-driven minefield population with a registered cell read port.
// Revision    : 1.0 - initial release
// ============================================================================
module mine_placer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_DIM   = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mine_placer_if.slave bus
);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_place = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [15:0]                      lfsr_q, lfsr_d;
    logic [5:0]                       mine_cnt_q, mine_cnt_d;
    logic [5:0]                       target_q, target_d;
    logic [4:0]                       board_dim_q, board_dim_d;
    logic                             done_q, done_d;
    logic                             rd_mine_q, rd_mine_d;
    logic [3:0]                       rd_adj_q, rd_adj_d;
    logic [MAX_DIM-1:0][MAX_DIM-1:0]  bitmap_q, bitmap_d;

    logic       w_strobe;
    logic [5:0] w_req_target;
    logic [3:0] w_cand_x;
    logic [3:0] w_cand_y;
    logic       w_accept;
    logic       w_rd_in;
    logic [4:0] w_nx;
    logic [4:0] w_ny;

    always_comb begin
        case (bus.button_num)
            5'd8:    w_req_target = 6'd8;
            5'd10:   w_req_target = 6'd20;
            5'd16:   w_req_target = 6'd50;
            default: w_req_target = 6'd0;
        endcase
    end

    assign w_strobe = (state_q == c_st_idle) && bus.level_enable && (bus.button_num != 5'd0);
    assign w_cand_x = lfsr_q[3:0];
    assign w_cand_y = lfsr_q[7:4];
    // The target check keeps the count from overshooting in the cycle it is reached.
    assign w_accept = (state_q == c_st_place) && (mine_cnt_q != target_q)
                    && ({1'b0, w_cand_x} < board_dim_q) && ({1'b0, w_cand_y} < board_dim_q)
                    && !bitmap_q[w_cand_y][w_cand_x];
    assign w_rd_in  = ({1'b0, bus.rd_x} < board_dim_q) && ({1'b0, bus.rd_y} < board_dim_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_st_idle;
            lfsr_q      <= LFSR_SEED;
            mine_cnt_q  <= 6'd0;
            target_q    <= 6'd0;
            board_dim_q <= 5'd0;
            done_q      <= 1'b0;
            rd_mine_q   <= 1'b0;
            rd_adj_q    <= 4'd0;
            bitmap_q    <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            mine_cnt_q  <= mine_cnt_d;
            target_q    <= target_d;
            board_dim_q <= board_dim_d;
            done_q      <= done_d;
            rd_mine_q   <= rd_mine_d;
            rd_adj_q    <= rd_adj_d;
            bitmap_q    <= bitmap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (w_strobe) begin
                    state_d = (w_req_target != 6'd0) ? c_st_place : c_st_done;
                end
            end
            c_st_place: begin
                if (w_accept && ((mine_cnt_q + 6'd1) == target_q)) begin
                    state_d = c_st_done;
                end
            end
            c_st_done: state_d = c_st_done;
            default:   state_d = c_st_idle;
        endcase
    end

    always_comb begin
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        done_d      = (state_q == c_st_done);
        board_dim_d = board_dim_q;
        target_d    = target_q;
        mine_cnt_d  = mine_cnt_q;
        bitmap_d    = bitmap_q;
        if (w_strobe) begin
            board_dim_d = bus.button_num;
            target_d    = w_req_target;
        end
        if (w_accept) begin
            bitmap_d[w_cand_y][w_cand_x] = 1'b1;
            mine_cnt_d                   = mine_cnt_q + 6'd1;
        end

        rd_mine_d = w_rd_in && bitmap_q[bus.rd_y][bus.rd_x];
        rd_adj_d  = 4'd0;
        w_nx      = 5'd0;
        w_ny      = 5'd0;
        if (w_rd_in) begin
            // Offsets of -1 wrap to 31 and +1 past the edge reaches 16; both fail the bound test.
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    w_nx = {1'b0, bus.rd_x} + 5'(dx);
                    w_ny = {1'b0, bus.rd_y} + 5'(dy);
                    if (!((dx == 0) && (dy == 0)) && (w_nx < board_dim_q) && (w_ny < board_dim_q)) begin
                        rd_adj_d = rd_adj_d + {3'd0, bitmap_q[w_ny[3:0]][w_nx[3:0]]};
                    end
                end
            end
        end
    end

    assign bus.busy      = (state_q == c_st_place);
    assign bus.done      = done_q;
    assign bus.mine_cnt  = mine_cnt_q;
    assign bus.board_dim = board_dim_q;
    assign bus.rd_mine   = rd_mine_q;
    assign bus.rd_adj    = rd_adj_q;
endmodule
`default_nettype wire

// File: tb/tb_mine_placer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mine_placer
// Description : Directed self-checking bench for mine_placer with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mine_placer;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic       mine;
        logic [3:0] adj;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mine_placer_if bus ();

    mine_placer #(.LFSR_SEED(SEED), .MAX_DIM(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the minefield, advanced on the same clock.
    logic [15:0] m_lfsr;
    int          m_state;
    logic        m_done;
    logic [4:0]  m_dim;
    int          m_target;
    int          m_cnt;
    logic        m_bm  [16][16];
    logic        ref_bm[16][16];
    rd_t         sb[$];

    function automatic int target_for(input logic [4:0] n);
        case (n)
            5'd8:    return 8;
            5'd10:   return 20;
            5'd16:   return 50;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr   <= SEED;
            m_state  <= 0;
            m_done   <= 1'b0;
            m_dim    <= 5'd0;
            m_target <= 0;
            m_cnt    <= 0;
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    m_bm[i][j] <= 1'b0;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_done <= (m_state == 2);
            if (m_state == 0) begin
                if (bus.level_enable && bus.button_num != 5'd0) begin
                    m_dim    <= bus.button_num;
                    m_target <= target_for(bus.button_num);
                    m_state  <= (target_for(bus.button_num) > 0) ? 1 : 2;
                end
            end else if (m_state == 1) begin
                if (m_cnt < m_target && m_lfsr[3:0] < m_dim && m_lfsr[7:4] < m_dim
                    && !m_bm[m_lfsr[7:4]][m_lfsr[3:0]]) begin
                    m_bm[m_lfsr[7:4]][m_lfsr[3:0]] <= 1'b1;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == m_target) m_state <= 2;
                end
            end
        end
    end

    function automatic rd_t exp_rd(input int x, input int y);
        rd_t r;
        int  d;
        int  adj;
        r   = '0;
        adj = 0;
        d   = int'(m_dim);
        if (x < d && y < d) begin
            r.mine = m_bm[y][x];
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    if (!(dx == 0 && dy == 0) && x + dx >= 0 && y + dy >= 0
                        && x + dx < d && y + dy < d && m_bm[y + dy][x + dx]) adj++;
                end
            end
            r.adj = 4'(adj);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: queue the read expectation for the address presented now, then
    // compare status and the popped read result on the following falling edge.
    task automatic tick();
        rd_t e;
        if (rst) sb.push_back('0);
        else     sb.push_back(exp_rd(int'(bus.rd_x), int'(bus.rd_y)));
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("rd_mine", bus.rd_mine, e.mine);
        chk("rd_adj", bus.rd_adj, e.adj);
        chk("busy", bus.busy, (m_state == 1));
        chk("done", bus.done, m_done);
        chk("mine_cnt", bus.mine_cnt, m_cnt);
        chk("board_dim", bus.board_dim, m_dim);
        chk("busy_done_exclusive", bus.busy & bus.done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic strobe(input logic [4:0] n);
        bus.level_enable = 1'b1;
        bus.button_num   = n;
        tick();
        bus.level_enable = 1'b0;
        bus.button_num   = 5'd0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        chk({tag, "_done_timeout"}, bus.done, 1);
    endtask

    task automatic sweep(input string tag, input int exp_count, input bit use_ref);
        int cnt;
        cnt = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                bus.rd_x = 4'(x);
                bus.rd_y = 4'(y);
                tick();
                if (bus.rd_mine === 1'b1) cnt++;
                if (use_ref) chk({tag, "_repeat_cell"}, bus.rd_mine, ref_bm[y][x]);
            end
        end
        chk({tag, "_count"}, cnt, exp_count);
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        bus.level_enable = 1'b0;
        bus.button_num   = 5'd0;
        bus.rd_x         = 4'd0;
        bus.rd_y         = 4'd0;

        do_reset();
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_mine_cnt", bus.mine_cnt, 0);
        chk("reset_board_dim", bus.board_dim, 0);
        chk("reset_rd", {bus.rd_mine, bus.rd_adj}, 0);

        // Zero-size strobe is ignored.
        strobe(5'd0);
        tick();
        chk("zero_strobe_busy", bus.busy, 0);
        chk("zero_strobe_dim", bus.board_dim, 0);

        // 8x8 run, kept as a reference layout.
        do_reset();
        repeat (3) tick();
        strobe(5'd8);
        chk("b8_busy_after_strobe", bus.busy, 1);
        wait_done("b8");
        chk("b8_mine_cnt", bus.mine_cnt, 8);
        chk("b8_busy_low", bus.busy, 0);
        chk("b8_dim", bus.board_dim, 8);
        sweep("b8", 8, 1'b0);
        ref_bm = m_bm;
        bus.rd_x = 4'd15;
        bus.rd_y = 4'd0;
        tick();
        chk("b8_offboard_read", {bus.rd_mine, bus.rd_adj}, 0);

        // Same reset-to-strobe delay must reproduce the same layout.
        do_reset();
        repeat (3) tick();
        strobe(5'd8);
        wait_done("b8_rerun");
        sweep("b8_rerun", 8, 1'b1);

        // 16x16 run.
        do_reset();
        repeat (7) tick();
        strobe(5'd16);
        wait_done("b16");
        chk("b16_mine_cnt", bus.mine_cnt, 50);
        sweep("b16", 50, 1'b0);
        bus.rd_x = 4'd0;
        bus.rd_y = 4'd0;
        tick();
        chk("b16_corner_adj_le3", (bus.rd_adj <= 4'd3), 1);

        // 10x10 run with a stray strobe during placement.
        do_reset();
        strobe(5'd10);
        chk("b10_busy", bus.busy, 1);
        strobe(5'd16);
        chk("b10_dim_kept", bus.board_dim, 10);
        wait_done("b10");
        chk("b10_mine_cnt", bus.mine_cnt, 20);
        chk("b10_dim", bus.board_dim, 10);
        sweep("b10", 20, 1'b0);

        // Unsupported size goes straight to done with an empty field.
        do_reset();
        strobe(5'd5);
        chk("b5_done_first_edge", bus.done, 0);
        chk("b5_busy", bus.busy, 0);
        tick();
        chk("b5_done_second_edge", bus.done, 1);
        chk("b5_busy_low", bus.busy, 0);
        chk("b5_mine_cnt", bus.mine_cnt, 0);
        sweep("b5", 0, 1'b0);

        // Reset in the middle of placement.
        do_reset();
        strobe(5'd8);
        n = 0;
        while (bus.mine_cnt !== 6'd3 && n < 4000) begin
            tick();
            n++;
        end
        chk("midrst_three_mines", bus.mine_cnt, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_mine_cnt", bus.mine_cnt, 0);
        chk("midrst_dim", bus.board_dim, 0);
        chk("midrst_rd", {bus.rd_mine, bus.rd_adj}, 0);
        sweep("midrst", 0, 1'b0);
        strobe(5'd8);
        wait_done("midrst_restart");
        chk("midrst_restart_cnt", bus.mine_cnt, 8);
        sweep("midrst_restart", 8, 1'b0);

        // Strobe coincident with reset is lost.
        rst              = 1'b1;
        bus.level_enable = 1'b1;
        bus.button_num   = 5'd8;
        tick();
        rst              = 1'b0;
        bus.level_enable = 1'b0;
        bus.button_num   = 5'd0;
        tick();
        chk("rst_strobe_busy", bus.busy, 0);
        chk("rst_strobe_dim", bus.board_dim, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
